// File: rtl/rst_seq.sv
// rst_seq: ordered, stretched reset release (memory, peripherals, CPU) with soft/watchdog re-sequencing
module rst_seq #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst_req,
  input  logic       wdt_expire,
  output logic       mem_rst_n,
  output logic       periph_rst_n,
  output logic       cpu_rst_n,
  output logic       rst_done,
  output logic       busy,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);
  typedef enum logic [1:0] {ASSERT, REL_MEM, REL_PERIPH, RUN} state_t;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic mem_d, periph_d, cpu_d, done_d;
  logic [1:0] cause_d;
  logic [7:0] count_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    mem_d = mem_rst_n;
    periph_d = periph_rst_n;
    cpu_d = cpu_rst_n;
    cause_d = rst_cause;
    count_d = rst_count;
    case (state)
      ASSERT: if (cnt == HOLD_LAST) begin
        state_d = REL_MEM;
        cnt_d = '0;
        mem_d = 1'b1;
      end
      REL_MEM: if (cnt == GAP_LAST) begin
        state_d = REL_PERIPH;
        cnt_d = '0;
        periph_d = 1'b1;
      end
      REL_PERIPH: if (cnt == GAP_LAST) begin
        state_d = RUN;
        cnt_d = '0;
        cpu_d = 1'b1;
      end
      default: begin
        cnt_d = cnt;
        if (soft_rst_req || wdt_expire) begin
          state_d = ASSERT;
          cnt_d = '0;
          mem_d = 1'b0;
          periph_d = 1'b0;
          cpu_d = 1'b0;
          cause_d = wdt_expire ? 2'd2 : 2'd1;
          count_d = (&rst_count) ? rst_count : rst_count + 1'b1;
        end
      end
    endcase
    done_d = (state_d == RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ASSERT;
      cnt <= '0;
      mem_rst_n <= 1'b0;
      periph_rst_n <= 1'b0;
      cpu_rst_n <= 1'b0;
      rst_done <= 1'b0;
      busy <= 1'b1;
      rst_cause <= 2'd0;
      rst_count <= 8'd0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      mem_rst_n <= mem_d;
      periph_rst_n <= periph_d;
      cpu_rst_n <= cpu_d;
      rst_done <= done_d;
      busy <= ~done_d;
      rst_cause <= cause_d;
      rst_count <= count_d;
    end
  end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq, expected output changes queued with their edge numbers
module tb_rst_seq;
  localparam int HOLD = 16;
  localparam int GAP = 4;
  typedef struct {
    int e;
    int sc;
    logic [14:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soft_rst_req = 1'b0;
  logic wdt_expire = 1'b0;
  logic mem_rst_n, periph_rst_n, cpu_rst_n, rst_done, busy;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;
  exp_t exp_q[$];
  int edge_n = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit stim_done = 1'b0;
  bit final_done = 1'b0;
  rst_seq #(.HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .soft_rst_req(soft_rst_req),
    .wdt_expire(wdt_expire),
    .mem_rst_n(mem_rst_n),
    .periph_rst_n(periph_rst_n),
    .cpu_rst_n(cpu_rst_n),
    .rst_done(rst_done),
    .busy(busy),
    .rst_cause(rst_cause),
    .rst_count(rst_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  assert property (@(posedge clk) (!cpu_rst_n || periph_rst_n) && (!periph_rst_n || mem_rst_n));
  task automatic push(input int e, input int sc, input logic [2:0] rel, input logic [1:0] ca, input logic [7:0] cn);
    exp_t x;
    x.e = e;
    x.sc = sc;
    x.v = {rel, rel[0], ~rel[0], ca, cn};
    exp_q.push_back(x);
  endtask
  task automatic seq(input int b, input int sc, input logic [1:0] ca, input logic [7:0] cn);
    push(b + HOLD, sc, 3'b100, ca, cn);
    push(b + HOLD + GAP, sc, 3'b110, ca, cn);
    push(b + HOLD + 2 * GAP, sc, 3'b111, ca, cn);
  endtask
  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask
  logic [14:0] cur, prev;
  bit first = 1'b1;
  exp_t x;
  always @(negedge clk) begin
    cur = {mem_rst_n, periph_rst_n, cpu_rst_n, rst_done, busy, rst_cause, rst_count};
    n_cmp++;
    if ((cpu_rst_n && !periph_rst_n) || (periph_rst_n && !mem_rst_n)) begin
      n_bad++;
      $display("FAIL ordering edge=%0d got mem/per/cpu=%b%b%b, want monotonic release", edge_n, mem_rst_n, periph_rst_n, cpu_rst_n);
    end
    if (first || cur !== prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change edge=%0d got vec=%h, want no change", edge_n, cur);
      end else begin
        x = exp_q.pop_front();
        if (x.e != edge_n || cur !== x.v) begin
          n_bad++;
          $display("FAIL sc%0d_event got edge=%0d vec=%h, want edge=%0d vec=%h", x.sc, edge_n, cur, x.e, x.v);
        end
      end
    end
    first = 1'b0;
    prev = cur;
    if (stim_done && !final_done) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover_events got %0d pending (next edge=%0d), want 0", exp_q.size(), exp_q[0].e);
      end
      final_done = 1'b1;
    end
  end
  initial begin
    int r;
    logic [7:0] cn;
    cn = 8'd0;
    push(1, 0, 3'b000, 2'd0, 8'd0);
    wait_to(3);
    rst = 1'b0;
    seq(3, 0, 2'd0, cn);
    wait_to(3 + HOLD + 2 * GAP + 2);
    r = edge_n + 1;
    cn = cn + 8'd1;
    soft_rst_req = 1'b1;
    push(r, 1, 3'b000, 2'd1, cn);
    seq(r, 1, 2'd1, cn);
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_to(r + HOLD + 2 * GAP + 2);
    r = edge_n + 1;
    cn = cn + 8'd1;
    soft_rst_req = 1'b1;
    wdt_expire = 1'b1;
    push(r, 2, 3'b000, 2'd2, cn);
    seq(r, 2, 2'd2, cn);
    @(negedge clk);
    soft_rst_req = 1'b0;
    wdt_expire = 1'b0;
    wait_to(r + HOLD + 2 * GAP + 2);
    r = edge_n + 1;
    cn = cn + 8'd1;
    soft_rst_req = 1'b1;
    push(r, 3, 3'b000, 2'd1, cn);
    seq(r, 3, 2'd1, cn);
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_to(r + HOLD + 1);
    wdt_expire = 1'b1;
    @(negedge clk);
    wdt_expire = 1'b0;
    wait_to(r + HOLD + 2 * GAP + 2);
    r = edge_n + 1;
    cn = cn + 8'd1;
    soft_rst_req = 1'b1;
    push(r, 4, 3'b000, 2'd1, cn);
    push(r + HOLD, 4, 3'b100, 2'd1, cn);
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_to(r + HOLD + 1);
    rst = 1'b1;
    cn = 8'd0;
    push(r + HOLD + 2, 4, 3'b000, 2'd0, cn);
    wait_to(r + HOLD + 2);
    rst = 1'b0;
    seq(r + HOLD + 2, 4, 2'd0, cn);
    wait_to(r + HOLD + 2 + HOLD + 2 * GAP);
    for (int i = 0; i < 260; i++) begin
      r = edge_n + 1;
      cn = (cn == 8'd255) ? cn : cn + 8'd1;
      soft_rst_req = 1'b1;
      push(r, 5, 3'b000, 2'd1, cn);
      seq(r, 5, 2'd1, cn);
      @(negedge clk);
      soft_rst_req = 1'b0;
      wait_to(r + HOLD + 2 * GAP);
    end
    wait_to(edge_n + 4);
    stim_done = 1'b1;
    wait_to(edge_n + 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Consumes the testbench/board clock and a raw synchronous reset.
- Produces an ordered, stretched reset release for the CPU subsystem: memory first, then peripherals, then CPU core.
- Also re-sequences on software or watchdog reset requests, and reports the cause and count of resets.
- Sits between the clock/reset source and the CPU top-level; every CPU-side active-low reset comes from this block.

Parameters:
- HOLD_CYCLES, 16: cycles all domains stay in reset after entering the ASSERT state. Legal range 1..2^CNT_W-1.
- STAGE_GAP, 4: cycles between successive domain releases. Legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the internal stage counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. Power-on/board reset, sampled on the rising edge of clk.
- soft_rst_req  in  1  software reset request. Level sampled each cycle; honoured only in RUN.
- wdt_expire  in  1  watchdog expiry. Level sampled each cycle; honoured only in RUN.
- mem_rst_n  out  1  memory-domain reset, active low, registered.
- periph_rst_n  out  1  peripheral-domain reset, active low, registered.
- cpu_rst_n  out  1  CPU-core reset, active low, registered.
- rst_done  out  1  high when all domains are released (state RUN).
- busy  out  1  high in any state other than RUN.
- rst_cause  out  2  cause of last sequence: 0 power-on, 1 software, 2 watchdog. Value 3 is never driven.
- rst_count  out  8  number of soft plus watchdog resets since the last rst. Saturates at 255.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, port rst. All state updates occur on the rising edge of clk.
- rst=1 values, held while rst=1:
  - state=ASSERT, cnt=0
  - mem_rst_n=0, periph_rst_n=0, cpu_rst_n=0
  - rst_done=0, busy=1
  - rst_cause=0, rst_count=0
- rst overrides every other input and can interrupt any state; it restarts the sequence from ASSERT.
- State ASSERT:
  - All three *_rst_n outputs are 0; cnt increments each edge.
  - When cnt==HOLD_CYCLES-1: go to REL_MEM, cnt<=0, mem_rst_n<=1.
- State REL_MEM:
  - cnt increments.
  - When cnt==STAGE_GAP-1: go to REL_PERIPH, cnt<=0, periph_rst_n<=1.
- State REL_PERIPH:
  - cnt increments.
  - When cnt==STAGE_GAP-1: go to RUN, cnt<=0, cpu_rst_n<=1, rst_done<=1, busy<=0.
- Release latency, counting rising edges after the first edge with rst=0:
  - mem_rst_n rises after HOLD_CYCLES edges.
  - periph_rst_n rises after HOLD_CYCLES+STAGE_GAP edges.
  - cpu_rst_n and rst_done rise after HOLD_CYCLES+2*STAGE_GAP edges.
- State RUN:
  - Outputs are stable.
  - If wdt_expire=1 or soft_rst_req=1 on an edge, then on that edge:
    - state<=ASSERT, cnt<=0
    - all *_rst_n<=0, rst_done<=0, busy<=1
    - rst_count<=rst_count+1, saturating at 255
    - rst_cause<=2 if wdt_expire=1 (wins on simultaneous assertion), else 1.
- Requests in non-RUN states (ASSERT, REL_MEM, REL_PERIPH) are ignored. They do not restart the sequence, change rst_cause or increment rst_count.
- A request held high across the end of a sequence is taken on the first RUN edge. The block then re-enters ASSERT, so a stuck request loops the sequence; that is the intended behaviour.
- Release ordering is monotonic: cpu_rst_n=1 implies periph_rst_n=1, which implies mem_rst_n=1. This holds on every cycle.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

Test Plan:
- Power-on, defaults: rst high for 3 cycles, then low.
  - mem_rst_n rises at edge 16, periph_rst_n at edge 20, cpu_rst_n/rst_done at edge 24.
  - busy falls at edge 24; rst_cause=0, rst_count=0.
- Soft reset: in RUN, pulse soft_rst_req for 1 cycle.
  - On the next edge all *_rst_n=0 and busy=1; rst_cause=1, rst_count=1.
  - Release timing matches the power-on case, 16/20/24 edges after the request edge.
- Simultaneous requests: in RUN, assert wdt_expire and soft_rst_req on the same cycle.
  - rst_cause=2, rst_count increments by exactly 1.
- Ignored request: pulse wdt_expire while in REL_MEM.
  - Sequence timing unchanged; rst_cause and rst_count unchanged.
- Mid-sequence rst: assert rst at edge 18 of a soft-reset sequence (periph_rst_n still 0, mem_rst_n 1).
  - mem_rst_n=0 on the next edge; rst_cause=0, rst_count=0.
  - Full 16/20/24 timeline restarts from the rst deassert.
- Saturation plus ordering assertion: issue 260 soft resets.
  - rst_count stops at 255.
  - A concurrent assertion checks cpu_rst_n→periph_rst_n→mem_rst_n monotonic ordering on every cycle.
